// File: rtl/wm_us_sched.sv
// wm_us_sched: periodic ultrasonic measurement scheduler.
// Issues a distance request every PERIOD_MS ms ticks, collects the result,
// keeps a 2^AVG_LOG2-sample moving average and a hysteretic near-object flag.
// Optional echo timeout is built in when the macro WM_US_TIMEOUT_EN is defined;
// without it the scheduler waits indefinitely and the timeout outputs are 0.
module wm_us_sched #(
  parameter int PERIOD_MS  = 100,
  parameter int TIMEOUT_MS = 40,
  parameter int NEAR_TH    = 20,
  parameter int HYST       = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clkCnt_1msEnd,
  input  logic       usDistEn,
  input  logic [7:0] usDist,
  output logic       distChkEn,
  output logic       usCtrlRst,
  output logic       usTimeout,
  output logic [7:0] distAvg,
  output logic       distValid,
  output logic       objNear
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SW     = 8 + AVG_LOG2;
  localparam int PW     = $clog2(PERIOD_MS + 1);
  localparam int TW     = $clog2(TIMEOUT_MS + 1);
  localparam int FW     = AVG_LOG2 + 1;
  localparam int REL_TH = (NEAR_TH + HYST > 255) ? 255 : NEAR_TH + HYST;

  localparam logic [PW-1:0] PER_END   = PW'(PERIOD_MS);
  localparam logic [TW-1:0] TMO_END   = TW'(TIMEOUT_MS);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [7:0]    NEAR_V    = 8'(NEAR_TH);
  localparam logic [7:0]    REL_V     = 8'(REL_TH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       per_cnt_q, per_cnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [7:0]          ring_q [DEPTH];
  logic [7:0]          ring_d [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                upd_q, upd_d;
  logic                chk_q, chk_d;
  logic [7:0]          avg_q, avg_d;
  logic                valid_q, valid_d;
  logic                near_q, near_d;

  logic                accept;
  logic                clr;
  logic [7:0]          sample;
  logic [7:0]          avg_new;

`ifdef WM_US_TIMEOUT_EN
  logic                tmo_hit;
  logic                tmo_pulse_q, tmo_pulse_d;
`endif

  // Sequencer: state, period/timeout tick counters and sample acceptance.
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    accept    = 1'b0;
    clr       = 1'b0;
    sample    = usDist;
`ifdef WM_US_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    // Period counter runs freely and saturates; it is zeroed in REQ.
    if (clkCnt_1msEnd && per_cnt_q != PER_END) per_cnt_d = per_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = REQ;
          clr     = 1'b1;
        end
      end
      REQ: begin
        per_cnt_d = '0;
        tmo_cnt_d = '0;
        state_d   = enable ? WAIT : IDLE;
      end
      WAIT: begin
        // A real result always beats a timeout tick in the same cycle.
        if (usDistEn) begin
          accept = 1'b1;
          sample = usDist;
        end else if (clkCnt_1msEnd) begin
          if (tmo_cnt_q != TMO_END) tmo_cnt_d = tmo_cnt_q + 1'b1;
`ifdef WM_US_TIMEOUT_EN
          if (tmo_cnt_q == TMO_END - 1'b1) begin
            tmo_hit = 1'b1;
            accept  = 1'b1;
            sample  = 8'hFF;
          end
`endif
        end
        if (accept) state_d = enable ? GAP : IDLE;
      end
      GAP: begin
        if (!enable)                   state_d = IDLE;
        else if (per_cnt_q == PER_END) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    chk_d = (state_d == REQ);
`ifdef WM_US_TIMEOUT_EN
    tmo_pulse_d = tmo_hit;
`endif
  end

  // Averaging datapath: ring buffer, running sum, window fill and outputs.
  always_comb begin
    ring_d   = ring_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    upd_d    = accept;
    avg_d    = avg_q;
    valid_d  = valid_q;
    near_d   = near_q;
    avg_new  = sum_q[SW-1:AVG_LOG2];
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) ring_d[i] = '0;
      wr_ptr_d = '0;
      sum_d    = '0;
      fill_d   = '0;
      upd_d    = 1'b0;
      valid_d  = 1'b0;
      near_d   = 1'b0;
    end else begin
      if (accept) begin
        // The slot being overwritten holds the oldest sample.
        ring_d[wr_ptr_q] = sample;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        sum_d            = sum_q - SW'(ring_q[wr_ptr_q]) + SW'(sample);
        if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      end
      // Publish the new average one edge after the sum, only once full.
      if (upd_q && fill_q == FILL_FULL) begin
        avg_d   = avg_new;
        valid_d = 1'b1;
        if (avg_new < NEAR_V)       near_d = 1'b1;
        else if (avg_new >= REL_V)  near_d = 1'b0;
      end
    end
  end

  // Register stage for all state; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_ptr_q  <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      upd_q     <= 1'b0;
      chk_q     <= 1'b0;
      avg_q     <= '0;
      valid_q   <= 1'b0;
      near_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= ring_d[i];
      wr_ptr_q  <= wr_ptr_d;
      sum_q     <= sum_d;
      fill_q    <= fill_d;
      upd_q     <= upd_d;
      chk_q     <= chk_d;
      avg_q     <= avg_d;
      valid_q   <= valid_d;
      near_q    <= near_d;
    end
  end

`ifdef WM_US_TIMEOUT_EN
  // Timeout pulse register, shared by usTimeout and usCtrlRst.
  always_ff @(posedge clk) begin
    if (rst) tmo_pulse_q <= 1'b0;
    else     tmo_pulse_q <= tmo_pulse_d;
  end
  assign usTimeout = tmo_pulse_q;
  assign usCtrlRst = tmo_pulse_q;
`else
  assign usTimeout = 1'b0;
  assign usCtrlRst = 1'b0;
`endif

  assign distChkEn = chk_q;
  assign distAvg   = avg_q;
  assign distValid = valid_q;
  assign objNear   = near_q;

endmodule

// File: tb/tb_wm_us_sched.sv
// tb_wm_us_sched: directed bench for wm_us_sched with default parameters.
// Expectations follow the WM_US_TIMEOUT_EN setting of the build.
module tb_wm_us_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       tick_in = 1'b0;
  logic       us_en = 1'b0;
  logic [7:0] us_dist = 8'd0;
  logic       dist_chk, us_crst, us_tmo, dist_valid, obj_near;
  logic [7:0] dist_avg;

  wm_us_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .clkCnt_1msEnd(tick_in),
    .usDistEn(us_en), .usDist(us_dist), .distChkEn(dist_chk),
    .usCtrlRst(us_crst), .usTimeout(us_tmo), .distAvg(dist_avg),
    .distValid(dist_valid), .objNear(obj_near)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int chk_cnt = 0;
  int served_cnt = 0;
  int tick_idx = 0;
  int chk_wide = 0;
  int tmo_cyc = 0;
  int crst_cyc = 0;
  int chk_tick [64];
  bit chk_prev = 1'b0;

  // Output monitor on the falling edge: pulse counts and widths.
  always @(negedge clk) begin
    if (dist_chk === 1'b1) begin
      if (chk_cnt < 64) chk_tick[chk_cnt] = tick_idx;
      chk_cnt = chk_cnt + 1;
      if (chk_prev) chk_wide = chk_wide + 1;
    end
    chk_prev = (dist_chk === 1'b1);
    if (us_tmo === 1'b1)  tmo_cyc = tmo_cyc + 1;
    if (us_crst === 1'b1) crst_cyc = crst_cyc + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    tick_idx++;
    cyc();
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance ms ticks until an unanswered request is outstanding.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (chk_cnt == served_cnt && n < 250) begin
      tick();
      n++;
    end
    if (chk_cnt == served_cnt) begin
      vectors++; miscompares++;
      $display("FAIL %s: no distChkEn after %0d ticks", tag, n);
    end
  endtask

  task automatic reply(input logic [7:0] d);
    us_en = 1'b1;
    us_dist = d;
    cyc();
    us_en = 1'b0;
    served_cnt++;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    vectors++; if (dist_chk !== 1'b0)   begin miscompares++; $display("FAIL rst_chk: got %b want 0", dist_chk); end
    vectors++; if (us_crst !== 1'b0)    begin miscompares++; $display("FAIL rst_crst: got %b want 0", us_crst); end
    vectors++; if (us_tmo !== 1'b0)     begin miscompares++; $display("FAIL rst_tmo: got %b want 0", us_tmo); end
    vectors++; if (dist_avg !== 8'd0)   begin miscompares++; $display("FAIL rst_avg: got %0d want 0", dist_avg); end
    vectors++; if (dist_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", dist_valid); end
    vectors++; if (obj_near !== 1'b0)   begin miscompares++; $display("FAIL rst_near: got %b want 0", obj_near); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_average();
    logic exp_v [4];
    exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b0; exp_v[3] = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req("avg_req");
      reply(8'd40);
      vectors++; if (dist_valid !== exp_v[k]) begin miscompares++; $display("FAIL avg_valid%0d: got %b want %b", k, dist_valid, exp_v[k]); end
      if (k < 3) begin
        vectors++; if (dist_avg !== 8'd0) begin miscompares++; $display("FAIL avg_hold%0d: got %0d want 0", k, dist_avg); end
      end
    end
    vectors++; if (dist_avg !== 8'd40) begin miscompares++; $display("FAIL avg40: got %0d want 40", dist_avg); end
    vectors++; if (obj_near !== 1'b0)  begin miscompares++; $display("FAIL avg_near: got %b want 0", obj_near); end
    for (int k = 1; k < 4; k++) begin
      vectors++;
      if (chk_tick[k] - chk_tick[k-1] !== 100) begin
        miscompares++; $display("FAIL period%0d: got %0d ticks want 100", k, chk_tick[k] - chk_tick[k-1]);
      end
    end
    vectors++; if (chk_wide !== 0) begin miscompares++; $display("FAIL chk_width: got %0d wide pulses want 0", chk_wide); end
  endtask

  task automatic test_near_hyst();
    logic [7:0] smp [8];
    logic [7:0] exp_a [8];
    logic       exp_n [8];
    smp   = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd22, 8'd22, 8'd22, 8'd30};
    exp_a = '{8'd40, 8'd40, 8'd40, 8'd10, 8'd13, 8'd16, 8'd19, 8'd24};
    exp_n = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    enable = 1'b0;
    cyc(); cyc();
    enable = 1'b1;
    wait_req("near_req0");
    vectors++; if (dist_valid !== 1'b0) begin miscompares++; $display("FAIL restart_valid: got %b want 0", dist_valid); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) wait_req("near_req");
      reply(smp[k]);
      vectors++; if (dist_avg !== exp_a[k]) begin miscompares++; $display("FAIL near_avg%0d: got %0d want %0d", k, dist_avg, exp_a[k]); end
      vectors++; if (obj_near !== exp_n[k]) begin miscompares++; $display("FAIL near_flag%0d: got %b want %b", k, obj_near, exp_n[k]); end
    end
  endtask

  task automatic test_timeout();
    int c0, t0, r0;
    wait_req("tmo_req");
    c0 = chk_cnt; t0 = tmo_cyc; r0 = crst_cyc;
    ticks(40);
`ifdef WM_US_TIMEOUT_EN
    served_cnt++;
    vectors++; if (tmo_cyc - t0 !== 1)  begin miscompares++; $display("FAIL tmo_pulse: got %0d cycles want 1", tmo_cyc - t0); end
    vectors++; if (crst_cyc - r0 !== 1) begin miscompares++; $display("FAIL tmo_crst: got %0d cycles want 1", crst_cyc - r0); end
    vectors++; if (dist_avg !== 8'd82)  begin miscompares++; $display("FAIL tmo_avg: got %0d want 82", dist_avg); end
    vectors++; if (chk_cnt !== c0)      begin miscompares++; $display("FAIL tmo_noreq: got %0d want %0d", chk_cnt, c0); end
`else
    vectors++; if (tmo_cyc - t0 !== 0)  begin miscompares++; $display("FAIL tmo_pulse: got %0d cycles want 0", tmo_cyc - t0); end
    vectors++; if (crst_cyc - r0 !== 0) begin miscompares++; $display("FAIL tmo_crst: got %0d cycles want 0", crst_cyc - r0); end
    vectors++; if (dist_avg !== 8'd24)  begin miscompares++; $display("FAIL tmo_avg: got %0d want 24", dist_avg); end
    ticks(70);
    vectors++; if (chk_cnt !== c0)      begin miscompares++; $display("FAIL tmo_noreq: got %0d want %0d", chk_cnt, c0); end
    reply(8'd50);
    vectors++; if (dist_avg !== 8'd31)  begin miscompares++; $display("FAIL late_avg: got %0d want 31", dist_avg); end
    vectors++; if (chk_cnt !== c0 + 1)  begin miscompares++; $display("FAIL late_req: got %0d want %0d", chk_cnt, c0 + 1); end
`endif
  endtask

  task automatic test_coincident();
    int t0;
    logic [7:0] exp_avg;
`ifdef WM_US_TIMEOUT_EN
    exp_avg = 8'd91;
`else
    exp_avg = 8'd40;
`endif
    wait_req("coin_req");
    t0 = tmo_cyc;
    ticks(39);
    tick_in = 1'b1; us_en = 1'b1; us_dist = 8'd60;
    cyc();
    tick_in = 1'b0; us_en = 1'b0;
    tick_idx++; served_cnt++;
    cyc(); cyc(); cyc(); cyc();
    vectors++; if (tmo_cyc !== t0)      begin miscompares++; $display("FAIL coin_tmo: got %0d cycles want %0d", tmo_cyc, t0); end
    vectors++; if (dist_avg !== exp_avg) begin miscompares++; $display("FAIL coin_avg: got %0d want %0d", dist_avg, exp_avg); end
    vectors++; if (obj_near !== 1'b0)   begin miscompares++; $display("FAIL coin_near: got %b want 0", obj_near); end
  endtask

  task automatic test_stop();
    int c0;
    logic [7:0] a0;
    a0 = dist_avg;
    c0 = chk_cnt;
    enable = 1'b0;
    ticks(150);
    vectors++; if (chk_cnt !== c0)      begin miscompares++; $display("FAIL stop_noreq: got %0d want %0d", chk_cnt, c0); end
    vectors++; if (dist_avg !== a0)     begin miscompares++; $display("FAIL stop_avg: got %0d want %0d", dist_avg, a0); end
    vectors++; if (dist_valid !== 1'b1) begin miscompares++; $display("FAIL stop_valid: got %b want 1", dist_valid); end
  endtask

  task automatic test_reset_wait();
    int c0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req("rw_req");
      reply(8'd5);
    end
    vectors++; if (dist_avg !== 8'd5)   begin miscompares++; $display("FAIL rw_avg: got %0d want 5", dist_avg); end
    vectors++; if (obj_near !== 1'b1)   begin miscompares++; $display("FAIL rw_near: got %b want 1", obj_near); end
    wait_req("rw_wait");
    vectors++; if (dist_valid !== 1'b1) begin miscompares++; $display("FAIL rw_valid: got %b want 1", dist_valid); end
    rst = 1'b1; enable = 1'b0;
    cyc();
    vectors++; if (dist_chk !== 1'b0)   begin miscompares++; $display("FAIL rw_chk: got %b want 0", dist_chk); end
    vectors++; if (us_crst !== 1'b0)    begin miscompares++; $display("FAIL rw_crst: got %b want 0", us_crst); end
    vectors++; if (us_tmo !== 1'b0)     begin miscompares++; $display("FAIL rw_tmo: got %b want 0", us_tmo); end
    vectors++; if (dist_avg !== 8'd0)   begin miscompares++; $display("FAIL rw_avg0: got %0d want 0", dist_avg); end
    vectors++; if (dist_valid !== 1'b0) begin miscompares++; $display("FAIL rw_valid0: got %b want 0", dist_valid); end
    vectors++; if (obj_near !== 1'b0)   begin miscompares++; $display("FAIL rw_near0: got %b want 0", obj_near); end
    rst = 1'b0;
    served_cnt = chk_cnt;
    c0 = chk_cnt;
    cyc();
    us_en = 1'b1; us_dist = 8'd99;
    cyc();
    us_en = 1'b0;
    cyc(); cyc(); cyc();
    vectors++; if (dist_avg !== 8'd0)   begin miscompares++; $display("FAIL late_en_avg: got %0d want 0", dist_avg); end
    vectors++; if (dist_valid !== 1'b0) begin miscompares++; $display("FAIL late_en_valid: got %b want 0", dist_valid); end
    vectors++; if (chk_cnt !== c0)      begin miscompares++; $display("FAIL late_en_req: got %0d want %0d", chk_cnt, c0); end
    enable = 1'b1;
    cyc(); cyc();
    vectors++; if (chk_cnt !== c0 + 1)  begin miscompares++; $display("FAIL idle_restart: got %0d want %0d", chk_cnt, c0 + 1); end
  endtask

  initial begin
    test_reset();
    test_average();
    test_near_hyst();
    test_timeout();
    test_coincident();
    test_stop();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
